calc_issue_ctrl: RTL and testbench

//  Initiator/host side of the arg_vld/res_vld arithmetic pipeline interface (the pipeline has no backpressure).
//  - Accepts operand tuples {a,b,c,d} from an upstream valid/ready source.
//  - Issues them to the pipeline with credit control, so every returning result always has a buffer slot.
//  - Buffers results and presents them downstream over valid/ready, in order.

---
 rtl/calc_pkg.sv | 21 ++
 rtl/calc_res_fifo.sv | 61 ++++++
 rtl/calc_issue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_calc_issue_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the calc issue controller.
// Operand tuple, issue FSM states and default data width.
package calc_pkg;

  localparam int CALC_WIDTH = 32;

  typedef struct packed {
    logic [CALC_WIDTH-1:0] a;
    logic [CALC_WIDTH-1:0] b;
    logic [CALC_WIDTH-1:0] c;
    logic [CALC_WIDTH-1:0] d;
  } operand_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    CLEAR,
    HOLD
  } issue_state_e;

endpackage

// File: rtl/calc_res_fifo.sv
// calc_res_fifo: result buffer with async reset, push/pop/clear.
// Ports: push_i/din_i write, pop_i read, clr_i zeroes pointers;
// dout_o head (0 when empty), count_o/full_o/empty_o status.
module calc_res_fifo
  import calc_pkg::*;
#(
  parameter int WIDTH     = CALC_WIDTH,
  parameter int RES_DEPTH = 8,
  localparam int CW       = $clog2(RES_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(RES_DEPTH);

  logic [WIDTH-1:0] mem_q [RES_DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = cnt_q == CW'(RES_DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (push_ok && !clr_i) begin
      mem_q[wr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/calc_issue_ctrl.sv
// calc_issue_ctrl: credit-based issue of operand tuples to a
// no-backpressure pipeline, in-order result buffering, flush.
// Ports: in_* upstream valid/ready, arg_* issue to pipe,
// res/res_vld pipe return, out_* downstream valid/ready,
// flush/flush_done drain handshake, err sticky error.
// Define CALC_ISSUE_WDOG_EN to add the return-timeout watchdog.
module calc_issue_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH     = CALC_WIDTH,
  parameter int RES_DEPTH = 8,
  parameter int PIPE_LAT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] arg_a,
  output logic [WIDTH-1:0] arg_b,
  output logic [WIDTH-1:0] arg_c,
  output logic [WIDTH-1:0] arg_d,
  output logic             arg_vld,
  input  logic [WIDTH-1:0] res,
  input  logic             res_vld,
  output logic [WIDTH-1:0] out_res,
  output logic             out_vld,
  input  logic             out_rdy,
  input  logic             flush,
  output logic             flush_done,
  output logic             err
);

  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(RES_DEPTH);

  issue_state_e     state_q, state_d;
  logic [CW-1:0]    infl_q, infl_d;
  logic [CW-1:0]    res_cnt;
  logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic             vld_q;
  logic             err_q;
  logic             f_full, f_empty;
  logic             credit, issue, clr;
  logic             ret_ok, ret_bad, ovf, wd_to;

  // Credit counts both in-flight and buffered results, so a
  // pop only frees a slot once res_cnt has actually dropped.
  assign credit  = ({1'b0, infl_q} + {1'b0, res_cnt}) < DEPTH_V;
  assign in_rdy  = (state_q == RUN) && credit && !flush;
  assign issue   = in_vld && in_rdy;
  assign ret_ok  = res_vld && (infl_q != '0);
  assign ret_bad = res_vld && (infl_q == '0);
  assign ovf     = ret_ok && f_full;
  assign clr     = state_q == CLEAR;

  calc_res_fifo #(
    .WIDTH     (WIDTH),
    .RES_DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ret_ok),
    .din_i   (res),
    .pop_i   (out_rdy),
    .clr_i   (clr),
    .dout_o  (out_res),
    .count_o (res_cnt),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  assign out_vld    = !f_empty;
  assign flush_done = clr;
  assign err        = err_q;
  assign arg_a      = a_q;
  assign arg_b      = b_q;
  assign arg_c      = c_q;
  assign arg_d      = d_q;
  assign arg_vld    = vld_q;

  always_comb begin
    infl_d = infl_q;
    if (issue && !ret_ok) begin
      infl_d = infl_q + 1'b1;
    end else if (!issue && ret_ok) begin
      infl_d = infl_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush) state_d = DRAIN;
      DRAIN:   if (infl_q == '0) state_d = CLEAR;
      CLEAR:   state_d = flush ? HOLD : RUN;
      HOLD:    if (!flush) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      infl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      infl_q  <= infl_d;
      vld_q   <= issue;
      err_q   <= err_q | ovf | ret_bad | wd_to;
      if (issue) begin
        a_q <= in_a;
        b_q <= in_b;
        c_q <= in_c;
        d_q <= in_d;
      end
    end
  end

`ifdef CALC_ISSUE_WDOG_EN
  localparam int AW  = $clog2(RES_DEPTH);
  localparam int AGW = $clog2(2 * PIPE_LAT + 1);
  localparam logic [AGW-1:0] AGE_LIM = AGW'(2 * PIPE_LAT);

  // Returns are in order, so slots form a ring: tail takes a
  // new issue, head is the oldest outstanding one.
  logic [AGW-1:0]       age_q [RES_DEPTH];
  logic [RES_DEPTH-1:0] busy_q;
  logic [AW-1:0]        wt_q;
  logic [AW-1:0]        wh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      wt_q   <= '0;
      wh_q   <= '0;
      for (int i = 0; i < RES_DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RES_DEPTH; i++) begin
        if (busy_q[i] && age_q[i] != AGE_LIM) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
      if (issue) begin
        busy_q[wt_q] <= 1'b1;
        age_q[wt_q]  <= '0;
        wt_q         <= wt_q + 1'b1;
      end
      if (ret_ok) begin
        busy_q[wh_q] <= 1'b0;
        wh_q         <= wh_q + 1'b1;
      end
    end
  end

  assign wd_to = busy_q[wh_q] && (age_q[wh_q] == AGE_LIM);
`else
  assign wd_to = 1'b0;
`endif

endmodule

// File: tb/tb_calc_issue_ctrl.sv
// tb_calc_issue_ctrl: vectors, directed corner sequences and
// random traffic against a queue-based model of calc_issue_ctrl.
module tb_calc_issue_ctrl;
  import calc_pkg::*;

  localparam int W = 32;
  localparam int D = 8;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_a, in_b, in_c, in_d;
  logic         in_vld, in_rdy;
  logic [W-1:0] arg_a, arg_b, arg_c, arg_d;
  logic         arg_vld;
  logic [W-1:0] res;
  logic         res_vld;
  logic [W-1:0] out_res;
  logic         out_vld, out_rdy;
  logic         flush, flush_done, err;

  always #5 clk = ~clk;

  calc_issue_ctrl #(.WIDTH(W), .RES_DEPTH(D), .PIPE_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .arg_a(arg_a), .arg_b(arg_b), .arg_c(arg_c), .arg_d(arg_d),
    .arg_vld(arg_vld),
    .res(res), .res_vld(res_vld),
    .out_res(out_res), .out_vld(out_vld), .out_rdy(out_rdy),
    .flush(flush), .flush_done(flush_done), .err(err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [W-1:0] fcalc(operand_t o);
    return o.a - o.b + o.c * o.d;
  endfunction

  // Model pipeline: fixed latency L, optional drop of one issue.
  logic [L-1:0] p_vld = '0;
  logic [W-1:0] p_res [L];
  int           p_n = 0;
  int           drop_at = -1;

  always @(posedge clk) begin
    if (arg_vld) p_n <= p_n + 1;
    p_vld <= {p_vld[L-2:0], arg_vld && (p_n != drop_at)};
    p_res[0] <= fcalc({arg_a, arg_b, arg_c, arg_d});
    for (int i = 1; i < L; i++) p_res[i] <= p_res[i-1];
  end

  assign res     = p_res[L-1];
  assign res_vld = p_vld[L-1];

  // Reference model: accepted-not-popped results in order.
  operand_t     src_q[$];
  operand_t     iss_q[$];
  logic [W-1:0] exp_q[$];
  int           n_argv = 0;
  int           n_ret = 0;
  int           n_acc = 0;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      iss_q.delete();
    end else begin
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) chk("pop_unexpected", 1'b1, 1'b0);
        else chk("out_order", out_res, exp_q.pop_front());
      end
      if (flush_done) exp_q.delete();
      if (arg_vld) begin
        n_argv++;
        if (iss_q.size() == 0) chk("arg_unexpected", 1'b1, 1'b0);
        else chk("arg_vals", {arg_a, arg_b, arg_c, arg_d},
                 iss_q.pop_front());
      end
      if (in_vld && in_rdy) begin
        exp_q.push_back(fcalc(src_q[0]));
        iss_q.push_back(src_q[0]);
        void'(src_q.pop_front());
        n_acc++;
      end
      if (res_vld) n_ret++;
    end
  end

  int rdy_pct = 0;
  int vld_pct = 100;
  bit chk_rdy = 1'b0;

  task automatic step();
    @(negedge clk);
    if (src_q.size() > 0 && $urandom_range(99) < vld_pct) begin
      in_vld = 1'b1;
      {in_a, in_b, in_c, in_d} = src_q[0];
    end else begin
      in_vld = 1'b0;
    end
    out_rdy = ($urandom_range(99) < rdy_pct);
    #1;
    if (chk_rdy) chk("in_rdy_credit", in_rdy, exp_q.size() < D);
  endtask

  function automatic operand_t rnd_op();
    operand_t o;
    o.a = $urandom;
    o.b = $urandom;
    o.c = $urandom_range(2000) - 1000;
    o.d = $urandom;
    return o;
  endfunction

  typedef struct {
    operand_t     op;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tv[6];

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int lat, k, base, ret0, cnt;
    tv[0] = '{op: '{a: 32'd5, b: 32'd2, c: 32'd1, d: 32'd1},
              exp: 32'd4};
    tv[1] = '{op: '{a: 32'd0, b: 32'd0, c: 32'd0, d: 32'd0},
              exp: 32'd0};
    tv[2] = '{op: '{a: 32'hFFFF_FFFD, b: 32'd4, c: 32'd2,
                    d: 32'hFFFF_FFFB}, exp: 32'hFFFF_FFEF};
    tv[3] = '{op: '{a: 32'h7FFF_FFFF, b: 32'hFFFF_FFFF, c: 32'd0,
                    d: 32'd0}, exp: 32'h8000_0000};
    tv[4] = '{op: '{a: 32'd10, b: 32'd20, c: 32'hFFFF_FFFD,
                    d: 32'd3}, exp: 32'hFFFF_FFED};
    tv[5] = '{op: '{a: 32'd100, b: 32'd1, c: 32'd7, d: 32'd6},
              exp: 32'd141};

    rst = 1'b1;
    {in_a, in_b, in_c, in_d} = '0;
    in_vld = 1'b0;
    out_rdy = 1'b0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_arg_vld", arg_vld, 1'b0);
    chk("rst_arg_a", arg_a, 32'd0);
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_out_res", out_res, 32'd0);
    chk("rst_flush_done", flush_done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_in_rdy", in_rdy, 1'b1);
    rst = 1'b0;

    // Single-op vectors
    for (int i = 0; i < 6; i++) begin
      src_q.push_back(tv[i].op);
      step();
      chk("vec_in_rdy", in_rdy, 1'b1);
      step();
      chk("vec_arg_vld", arg_vld, 1'b1);
      chk("vec_args", {arg_a, arg_b, arg_c, arg_d}, tv[i].op);
      lat = 0;
      for (k = 1; k <= 20; k++) begin
        step();
        if (out_vld) begin
          lat = k;
          break;
        end
      end
      chk("vec_latency", lat, L + 1);
      chk("vec_out_res", out_res, tv[i].exp);
      rdy_pct = 100;
      step();
      rdy_pct = 0;
      step();
      chk("vec_popped", out_vld, 1'b0);
    end

    // Back-pressure: credits cap issue at D
    base = n_argv;
    for (int i = 0; i < 10; i++) src_q.push_back(rnd_op());
    repeat (20) step();
    chk("bp_issued", n_argv - base, D);
    chk("bp_in_rdy", in_rdy, 1'b0);
    chk("bp_out_vld", out_vld, 1'b1);
    rdy_pct = 100;
    step();
    chk("bp_pop_same_cycle", in_rdy, 1'b0);
    rdy_pct = 0;
    step();
    chk("bp_pop_next_cycle", in_rdy, 1'b1);
    rdy_pct = 100;
    cnt = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && cnt < 200) begin
      step();
      cnt++;
    end
    chk("bp_drained", exp_q.size(), 0);

    // Simultaneous issue/return, continuous stream
    chk_rdy = 1'b1;
    base = n_acc;
    for (int i = 0; i < 20; i++) src_q.push_back(rnd_op());
    repeat (20) step();
    @(posedge clk);
    #1;
    chk("sim_accepts", n_acc - base, 20);
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 50) begin
      step();
      cnt++;
    end
    chk("sim_drained", exp_q.size(), 0);
    chk_rdy = 1'b0;

    // Flush: 2 buffered, 3 in flight
    rdy_pct = 0;
    src_q.push_back(rnd_op());
    src_q.push_back(rnd_op());
    repeat (9) step();
    chk("fl_buffered", out_vld, 1'b1);
    for (int i = 0; i < 3; i++) src_q.push_back(rnd_op());
    repeat (4) step();
    flush = 1'b1;
    step();
    chk("fl_in_rdy", in_rdy, 1'b0);
    ret0 = n_ret;
    lat = 0;
    for (k = 1; k <= 30; k++) begin
      step();
      if (flush_done) begin
        lat = k;
        break;
      end
    end
    chk("fl_done_seen", flush_done, 1'b1);
    chk("fl_drained_3", n_ret - ret0, 3);
    step();
    chk("fl_done_pulse", flush_done, 1'b0);
    chk("fl_out_vld", out_vld, 1'b0);
    chk("fl_hold_rdy", in_rdy, 1'b0);
    flush = 1'b0;
    step();
    chk("fl_run_rdy", in_rdy, 1'b1);
    chk("fl_err", err, 1'b0);

    // Random traffic
    chk_rdy = 1'b1;
    rdy_pct = 50;
    vld_pct = 70;
    for (int i = 0; i < 60; i++) src_q.push_back(rnd_op());
    cnt = 0;
    while (src_q.size() != 0 && cnt < 1000) begin
      step();
      cnt++;
    end
    rdy_pct = 100;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 100) begin
      step();
      cnt++;
    end
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_err", err, 1'b0);
    chk_rdy = 1'b0;
    vld_pct = 100;

    // Async reset with 5 in flight, then late returns
    rdy_pct = 0;
    for (int i = 0; i < 5; i++) src_q.push_back(rnd_op());
    repeat (6) step();
    chk("rs_in_flight", out_vld, 1'b0);
    rst = 1'b1;
    #1;
    chk("rs_arg_vld", arg_vld, 1'b0);
    chk("rs_arg", {arg_a, arg_b, arg_c, arg_d}, 128'd0);
    chk("rs_out_vld", out_vld, 1'b0);
    chk("rs_out_res", out_res, 32'd0);
    chk("rs_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) step();
    chk("rs_stray_err", err, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rs_err_clear", err, 1'b0);

    // Watchdog: one result never returns
    drop_at = p_n;
    src_q.push_back(tv[0].op);
    step();
    step();
    chk("wd_arg_vld", arg_vld, 1'b1);
    for (k = 1; k <= 2 * L + 1; k++) begin
      step();
      if (k == 2 * L) chk("wd_before", err, 1'b0);
    end
`ifdef CALC_ISSUE_WDOG_EN
    chk("wd_timeout", err, 1'b1);
`else
    chk("wd_disabled", err, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
